// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-side memory stage.
//   - MMIO register byte offsets inside the 4 KiB MMIO page
//   - bit positions inside TMR_CTRL and TMR_STAT
//   - address region enum produced by the top-level decoder
package dmem_pkg;

  localparam logic [11:0] OFF_LEDS      = 12'h000;
  localparam logic [11:0] OFF_CYCLE     = 12'h004;
  localparam logic [11:0] OFF_TMR_LOAD  = 12'h008;
  localparam logic [11:0] OFF_TMR_CTRL  = 12'h00C;
  localparam logic [11:0] OFF_TMR_STAT  = 12'h010;
  localparam logic [11:0] OFF_TMR_COUNT = 12'h014;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int STAT_EXP_BIT  = 0;
  localparam int STAT_ERR_BIT  = 1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: data bus between the single-cycle core and the data memory stage.
//   MemWrite  : store strobe (core -> memory)
//   ALUResult : byte address (core -> memory)
//   WriteData : store data   (core -> memory)
//   ReadData  : combinational load data (memory -> core)
// Modports: master = core side, slave = memory side.
interface dmem_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUResult, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUResult, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: countdown timer registers of the MMIO page.
// Owns TMR_LOAD, TMR_CTRL (EN/AUTO), TMR_COUNT and the EXPIRED flag and
// resolves same-cycle conflicts between the countdown and bus writes.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_wr_load/ctrl/stat   : qualified write strobes for the three writable regs
//   i_wdata               : store data
//   o_load, o_count       : TMR_LOAD / TMR_COUNT contents
//   o_en, o_auto          : TMR_CTRL bits
//   o_expired             : TMR_STAT EXPIRED (also drives the interrupt)
module mmio_timer
  import dmem_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_load,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_stat,
  input  logic [31:0]      i_wdata,
  output logic [CNT_W-1:0] o_load,
  output logic [CNT_W-1:0] o_count,
  output logic             o_en,
  output logic             o_auto,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_load, r_count, w_load_next, w_count_next;
  logic             r_en, r_auto, r_expired;
  logic             w_en_next, w_auto_next, w_expired_next, w_expire;

  // Countdown first, then bus writes on top: a write to LOAD/CTRL in the
  // same cycle overrides whatever the countdown decided, while expiry
  // overrides a same-cycle W1C of EXPIRED.
  always_comb begin
    w_load_next    = r_load;
    w_count_next   = r_count;
    w_en_next      = r_en;
    w_auto_next    = r_auto;
    w_expired_next = r_expired;
    w_expire       = 1'b0;

    if (r_en) begin
      if (r_count != '0) begin
        w_count_next = r_count - CNT_ONE;
      end else begin
        w_expire = 1'b1;
        if (r_auto) w_count_next = r_load;
        else        w_en_next    = 1'b0;
      end
    end

    if (i_wr_stat && i_wdata[STAT_EXP_BIT]) w_expired_next = 1'b0;
    if (w_expire)                           w_expired_next = 1'b1;

    if (i_wr_load) begin
      w_load_next  = i_wdata[CNT_W-1:0];
      w_count_next = i_wdata[CNT_W-1:0];
    end

    if (i_wr_ctrl) begin
      w_en_next   = i_wdata[CTRL_EN_BIT];
      w_auto_next = i_wdata[CTRL_AUTO_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load    <= '0;
      r_count   <= '0;
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_load    <= w_load_next;
      r_count   <= w_count_next;
      r_en      <= w_en_next;
      r_auto    <= w_auto_next;
      r_expired <= w_expired_next;
    end
  end

  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_en      = r_en;
  assign o_auto    = r_auto;
  assign o_expired = r_expired;

endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side memory stage for a single-cycle core.
// Word-addressed RAM plus a 4 KiB MMIO page (LED register, free-running
// cycle counter, countdown timer). Loads are combinational; stores commit
// at the rising clock edge. Address bits [1:0] are ignored.
// Ports:
//   clk, reset : clock, synchronous active-high reset (also discards stores)
//   bus        : dmem_if.slave (MemWrite, ALUResult, WriteData -> ReadData)
//   Leds       : LED register
//   TimerIrq   : timer EXPIRED flag
//   AccessErr  : only when DMEM_ACCESS_ERR_EN is defined; sticky flag set by
//                stores to unmapped addresses or read-only MMIO registers,
//                also visible as TMR_STAT bit1. Without the macro the port is
//                absent and TMR_STAT bit1 reads 0.
module data_mem_mmio
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic [31:0] Leds,
  output logic        TimerIrq
`ifdef DMEM_ACCESS_ERR_EN
  ,
  output logic        AccessErr
`endif
);

  localparam int               AW        = $clog2(RAM_WORDS);
  localparam logic [31:0]      RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [31:0]      r_ram [RAM_WORDS];
  logic [31:0]      r_leds;
  logic [CNT_W-1:0] r_cycle;

  region_e          w_region;
  logic [AW-1:0]    w_idx;
  logic [11:0]      w_off;
  logic             w_we, w_wr_mmio;
  logic [31:0]      w_rdata, w_ctrl_word, w_stat_word;
  logic             w_err;

  logic [CNT_W-1:0] w_tmr_load, w_tmr_count;
  logic             w_tmr_en, w_tmr_auto, w_tmr_expired;

  // RAM takes priority if a small MMIO_BASE were ever to overlap it.
  always_comb begin
    if (bus.ALUResult < RAM_BYTES)                       w_region = REG_RAM;
    else if (bus.ALUResult[31:12] == MMIO_BASE[31:12])   w_region = REG_MMIO;
    else                                                 w_region = REG_NONE;
  end

  assign w_idx     = bus.ALUResult[AW+1:2];
  assign w_off     = {bus.ALUResult[11:2], 2'b00};
  // A store in a reset cycle is dropped everywhere, RAM included.
  assign w_we      = bus.MemWrite && !reset;
  assign w_wr_mmio = w_we && (w_region == REG_MMIO);

  always_ff @(posedge clk) begin
    if (w_we && (w_region == REG_RAM)) r_ram[w_idx] <= bus.WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds  <= '0;
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_ONE;
      if (w_wr_mmio && (w_off == OFF_LEDS)) r_leds <= bus.WriteData;
    end
  end

  mmio_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wr_load (w_wr_mmio && (w_off == OFF_TMR_LOAD)),
    .i_wr_ctrl (w_wr_mmio && (w_off == OFF_TMR_CTRL)),
    .i_wr_stat (w_wr_mmio && (w_off == OFF_TMR_STAT)),
    .i_wdata   (bus.WriteData),
    .o_load    (w_tmr_load),
    .o_count   (w_tmr_count),
    .o_en      (w_tmr_en),
    .o_auto    (w_tmr_auto),
    .o_expired (w_tmr_expired)
  );

`ifdef DMEM_ACCESS_ERR_EN
  logic r_err;
  logic w_bad_wr;

  assign w_bad_wr = w_we && ((w_region == REG_NONE) ||
                    ((w_region == REG_MMIO) &&
                     ((w_off == OFF_CYCLE) || (w_off == OFF_TMR_COUNT))));

  always_ff @(posedge clk) begin
    if (reset)         r_err <= 1'b0;
    else if (w_bad_wr) r_err <= 1'b1;
  end

  assign w_err     = r_err;
  assign AccessErr = r_err;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_ctrl_word                = '0;
    w_ctrl_word[CTRL_EN_BIT]   = w_tmr_en;
    w_ctrl_word[CTRL_AUTO_BIT] = w_tmr_auto;
    w_stat_word                = '0;
    w_stat_word[STAT_EXP_BIT]  = w_tmr_expired;
    w_stat_word[STAT_ERR_BIT]  = w_err;
  end

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_RAM:  w_rdata = r_ram[w_idx];
      REG_MMIO: begin
        case (w_off)
          OFF_LEDS:      w_rdata = r_leds;
          OFF_CYCLE:     w_rdata = 32'(r_cycle);
          OFF_TMR_LOAD:  w_rdata = 32'(w_tmr_load);
          OFF_TMR_CTRL:  w_rdata = w_ctrl_word;
          OFF_TMR_STAT:  w_rdata = w_stat_word;
          OFF_TMR_COUNT: w_rdata = 32'(w_tmr_count);
          default:       w_rdata = '0;
        endcase
      end
      default:  w_rdata = '0;
    endcase
  end

  assign bus.ReadData = w_rdata;
  assign Leds         = r_leds;
  assign TimerIrq     = w_tmr_expired;

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed scenarios followed by random bus traffic, all
// checked against a behavioural model of the memory map kept in this file.
module tb_data_mem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Leds;
  logic        TimerIrq;
`ifdef DMEM_ACCESS_ERR_EN
  logic        AccessErr;
`endif

  dmem_if bus ();

  data_mem_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .Leds     (Leds),
    .TimerIrq (TimerIrq)
`ifdef DMEM_ACCESS_ERR_EN
    ,
    .AccessErr(AccessErr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state (64-word RAM, MMIO base 0x1000, 32-bit counters)
  logic [31:0] m_ram [64];
  logic [31:0] m_leds, m_cycle, m_load, m_count;
  logic        m_en, m_auto, m_exp, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    logic        err_vis;
`ifdef DMEM_ACCESS_ERR_EN
    err_vis = m_err;
`else
    err_vis = 1'b0;
`endif
    if (a < 32'd256) return m_ram[a[7:2]];
    if (a[31:12] != 20'h00001) return 32'h0;
    off = a & 32'h0000_0FFC;
    case (off)
      32'h00:  return m_leds;
      32'h04:  return m_cycle;
      32'h08:  return m_load;
      32'h0C:  return {30'b0, m_auto, m_en};
      32'h10:  return {30'b0, err_vis, m_exp};
      32'h14:  return m_count;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge worth of behaviour: the timer acts on the state seen
  // before the edge, then the store (if any) is applied on top.
  task automatic model_step(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit          fire, clr;
    logic [31:0] off;
    fire = 1'b0;
    clr  = 1'b0;
    if (rst) begin
      m_leds = 0; m_cycle = 0; m_load = 0; m_count = 0;
      m_en = 0; m_auto = 0; m_exp = 0; m_err = 0;
    end else begin
      m_cycle = m_cycle + 1;
      if (m_en) begin
        if (m_count != 0) m_count = m_count - 1;
        else begin
          fire = 1'b1;
          if (m_auto) m_count = m_load;
          else        m_en = 1'b0;
        end
      end
      if (we) begin
        off = a & 32'h0000_0FFC;
        if (a < 32'd256) m_ram[a[7:2]] = wd;
        else if (a[31:12] != 20'h00001) m_err = 1'b1;
        else begin
          case (off)
            32'h00: m_leds = wd;
            32'h08: begin m_load = wd; m_count = wd; end
            32'h0C: begin m_en = wd[0]; m_auto = wd[1]; end
            32'h10: clr = wd[0];
            32'h04, 32'h14: m_err = 1'b1;
            default: ;
          endcase
        end
      end
      if (fire)     m_exp = 1'b1;
      else if (clr) m_exp = 1'b0;
    end
  endtask

  // One bus transaction: drive, check the combinational load, take the
  // edge, advance the model, check the registered outputs.
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd);
    reset         = rst;
    bus.MemWrite  = we;
    bus.ALUResult = a;
    bus.WriteData = wd;
    #1;
    rd = bus.ReadData;
    chk($sformatf("read@%h", a), rd, model_read(a));
    @(posedge clk);
    model_step(rst, we, a, wd);
    #1;
    chk("leds", Leds, m_leds);
    chk("timer_irq", {31'b0, TimerIrq}, {31'b0, m_exp});
`ifdef DMEM_ACCESS_ERR_EN
    chk("access_err", {31'b0, AccessErr}, {31'b0, m_err});
`endif
    $display("[TB] t=%0t rst=%0b we=%0b addr=%h wdata=%h rdata=%h leds=%h irq=%0b",
             $time, rst, we, a, wd, rd, Leds, TimerIrq);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    step(1'b0, 1'b1, a, d, unused_rd);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    step(1'b0, 1'b0, a, 32'h0, d);
  endtask

  initial begin
    logic [31:0] r, c0, a, d;
    bit          we, rs;
    int unsigned sel;

    // Power-up reset, not checked: nothing is defined before it.
    reset = 1'b1; bus.MemWrite = 1'b0; bus.ALUResult = 32'h1000; bus.WriteData = 32'h0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    step(1'b1, 1'b0, 32'h1000, 32'h0, r);
    chk("rst_leds", Leds, 32'h0);
    chk("rst_irq", {31'b0, TimerIrq}, 32'h0);
    rd(32'h1014, r); chk("rst_count", r, 32'h0);

    // RAM store/load, low address bits ignored
    wr(32'h28, 32'hDEAD_BEEF);
    rd(32'h28, r); chk("ram_28", r, 32'hDEAD_BEEF);
    rd(32'h2B, r); chk("ram_2b", r, 32'hDEAD_BEEF);

    // LEDs, then reset and cycle counter restart
    wr(32'h1000, 32'h0000_00A5);
    chk("leds_a5", Leds, 32'hA5);
    step(1'b1, 1'b0, 32'h1000, 32'h0, r);
    chk("leds_rst", Leds, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(32'h1004, r);
      chk($sformatf("cycle_%0d", i), r, i);
    end

    // One-shot timer
    wr(32'h1008, 32'd3);
    wr(32'h100C, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(32'h1014, r);
      chk($sformatf("oneshot_count_%0d", i), r, 3 - i);
    end
    chk("oneshot_irq", {31'b0, TimerIrq}, 32'h1);
    rd(32'h100C, r); chk("oneshot_ctrl_cleared", r, 32'h0);
    wr(32'h1010, 32'h1);
    chk("w1c_irq", {31'b0, TimerIrq}, 32'h0);

    // Auto-reload: expiry every third edge; W1C in the expiry cycle loses
    wr(32'h1008, 32'd2);
    wr(32'h100C, 32'd3);
    rd(32'h1014, r); chk("auto_irq_1", {31'b0, TimerIrq}, 32'h0);
    rd(32'h1014, r); chk("auto_irq_2", {31'b0, TimerIrq}, 32'h0);
    rd(32'h1014, r); chk("auto_irq_3", {31'b0, TimerIrq}, 32'h1);
    wr(32'h1010, 32'h1); chk("auto_w1c", {31'b0, TimerIrq}, 32'h0);
    rd(32'h1014, r);     chk("auto_irq_5", {31'b0, TimerIrq}, 32'h0);
    wr(32'h1010, 32'h1); chk("auto_w1c_vs_expiry", {31'b0, TimerIrq}, 32'h1);
    wr(32'h100C, 32'h0);
    wr(32'h1010, 32'h1);

    // Unmapped and read-only stores
    rd(32'h1004, c0);
    wr(32'h0800, 32'h5555_5555);
`ifdef DMEM_ACCESS_ERR_EN
    chk("err_set", {31'b0, AccessErr}, 32'h1);
`endif
    wr(32'h1004, 32'h1234_5678);
    rd(32'h0800, r); chk("unmapped_0800", r, 32'h0);
    rd(32'h1018, r); chk("unmapped_1018", r, 32'h0);
    rd(32'h1004, r); chk("cycle_unaffected", r, c0 + 32'd5);
`ifdef DMEM_ACCESS_ERR_EN
    chk("err_sticky", {31'b0, AccessErr}, 32'h1);
`endif

    // Reset in the same cycle as a RAM store
    wr(32'h10, 32'h1);
    step(1'b1, 1'b1, 32'h10, 32'h7, r);
    rd(32'h10, r);   chk("ram_kept", r, 32'h1);
    rd(32'h1004, r); chk("rst_cycle", r, 32'h1);
    rd(32'h1000, r); chk("rst_mmio_leds", r, 32'h0);
    rd(32'h1008, r); chk("rst_mmio_load", r, 32'h0);
    rd(32'h100C, r); chk("rst_mmio_ctrl", r, 32'h0);
    rd(32'h1010, r); chk("rst_mmio_stat", r, 32'h0);
    rd(32'h1014, r); chk("rst_mmio_count", r, 32'h0);
`ifdef DMEM_ACCESS_ERR_EN
    chk("err_cleared", {31'b0, AccessErr}, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 64; i++) wr(i * 4, $urandom);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel < 4)      a = $urandom_range(0, 255);
      else if (sel < 8) begin
        a = 32'h1000 + $urandom_range(0, 31);
        if ($urandom_range(0, 3) != 0) d = $urandom_range(0, 7);
      end
      else if (sel == 8) a = $urandom;
      else               a = 32'h0000_00F0 + $urandom_range(0, 31);
      we = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 63) == 0);
      step(rs, we, a, d, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
